arb_rr_4: RTL and testbench

ARB_RR_4 -- requirements
Module: arb_rr_4

---
 rtl/arb_pkg.sv | 40 ++++
 rtl/arb_rr_4_if.sv | 44 ++++
 rtl/arb_enc_4to2.sv | 20 ++
 rtl/arb_rr_4.sv | 162 ++++++++++++++++
 tb/tb_arb_rr_4.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg -- shared definitions for the 4-way round-robin arbiter.
//
// Contents:
//   ARB_N       number of requesters (4)
//   ARB_IDX_W   width of a requester index (2)
//   HOLD_CNT_W  width of the grant-length counter used when ARB_TIMEOUT_EN
//               is defined (8)
//   arb_state_t IDLE (no owner) / BUSY (one owner)
//   rr_pick     one-hot winner of a circular search starting at a pointer
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_N      = 4;
  localparam int ARB_IDX_W  = 2;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Walking the candidates from last to first lets the earliest one in
  // search order overwrite any later match, so no break/flag is needed.
  function automatic logic [ARB_N-1:0] rr_pick(input logic [ARB_N-1:0]     req,
                                               input logic [ARB_IDX_W-1:0] ptr);
    logic [ARB_N-1:0]     pick;
    logic [ARB_IDX_W-1:0] idx;
    pick = '0;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      idx = ptr + ARB_IDX_W'(k);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_rr_4_if.sv
// -----------------------------------------------------------------------------
// arb_rr_4_if -- request/grant bundle between requesters and arb_rr_4.
//
// Signals:
//   req      [3:0] level-sensitive request vector, bit i = requester i
//   done           current owner releases the resource this cycle
//   gnt      [3:0] one-hot grant (zero when no owner)
//   gnt_idx  [1:0] binary index of the owner, holds its last value when idle
//   gnt_vld        high while a grant is active
//   tmo            one-cycle pulse after a forced (timeout) release
//
// Modports:
//   master  requester side (drives req/done)
//   slave   arbiter side   (drives gnt/gnt_idx/gnt_vld/tmo)
// -----------------------------------------------------------------------------
interface arb_rr_4_if;
  import arb_pkg::*;

  logic [ARB_N-1:0]     req;
  logic                 done;
  logic [ARB_N-1:0]     gnt;
  logic [ARB_IDX_W-1:0] gnt_idx;
  logic                 gnt_vld;
  logic                 tmo;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  tmo
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output tmo
  );

endinterface

// File: rtl/arb_enc_4to2.sv
// -----------------------------------------------------------------------------
// arb_enc_4to2 -- combinational one-hot to binary encoder.
//
// Ports:
//   onehot [3:0] in   one-hot (or zero) vector
//   idx    [1:0] out  binary index of the set bit (0 when onehot is zero)
// -----------------------------------------------------------------------------
module arb_enc_4to2
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     onehot,
  output logic [ARB_IDX_W-1:0] idx
);

  // OR-based encoding is exact for one-hot inputs, which is all the
  // arbiter ever feeds in.
  assign idx[0] = onehot[1] | onehot[3];
  assign idx[1] = onehot[2] | onehot[3];

endmodule

// File: rtl/arb_rr_4.sv
// -----------------------------------------------------------------------------
// arb_rr_4 -- 4-requester round-robin arbiter with registered grant and
// zero-bubble handover between owners.
//
// Parameters:
//   HOLD_MAX  maximum grant length in cycles (1..255); only has an effect
//             when the ARB_TIMEOUT_EN macro is defined
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of arb_rr_4_if (req/done in, gnt/gnt_idx/gnt_vld/tmo out)
//
// Build option:
//   ARB_TIMEOUT_EN  adds an 8-bit hold counter that forces a release after
//                   HOLD_MAX cycles and pulses tmo; without it grants are
//                   unbounded and tmo is tied low.
// -----------------------------------------------------------------------------
module arb_rr_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic      clk,
  input  logic      rst,
  arb_rr_4_if.slave bus
);

  // Out-of-range hold limits are rejected at elaboration in every build.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("arb_rr_4: HOLD_MAX must be in 1..255");
  end

  arb_state_t           state;
  arb_state_t           next_state;
  logic [ARB_N-1:0]     gnt_q;
  logic [ARB_N-1:0]     next_gnt;
  logic [ARB_IDX_W-1:0] idx_q;
  logic [ARB_IDX_W-1:0] next_idx;
  logic [ARB_IDX_W-1:0] ptr_q;
  logic [ARB_IDX_W-1:0] next_ptr;
  logic [ARB_IDX_W-1:0] rel_ptr;
  logic [ARB_N-1:0]     pick_idle;
  logic [ARB_N-1:0]     pick_rel;
  logic                 release_now;
  logic                 new_grant;
  logic                 hold_expired;

  // After a release the search restarts just past the old owner, which
  // automatically makes the old owner the last candidate.
  assign rel_ptr   = idx_q + ARB_IDX_W'(1);
  assign pick_idle = rr_pick(bus.req, ptr_q);
  assign pick_rel  = rr_pick(bus.req, rel_ptr);

  // done and a dropped request together still make a single release.
  assign release_now = bus.done | ~bus.req[idx_q] | hold_expired;

  arb_enc_4to2 u_enc (
    .onehot (next_gnt),
    .idx    (next_idx)
  );

  // State and grant registers; gnt_idx only loads on a new grant so it
  // keeps the last owner's index while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      state <= next_state;
      gnt_q <= next_gnt;
      ptr_q <= next_ptr;
      if (new_grant) begin
        idx_q <= next_idx;
      end
    end
  end

  // Next-state logic: arbitrate from IDLE, or on release arbitrate again
  // in the same edge so a waiting requester takes over with no gap.
  always_comb begin
    next_state = state;
    next_gnt   = gnt_q;
    next_ptr   = ptr_q;
    new_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          next_gnt   = pick_idle;
          next_state = BUSY;
          new_grant  = 1'b1;
        end
      end
      BUSY: begin
        if (release_now) begin
          next_ptr = rel_ptr;
          if (|pick_rel) begin
            next_gnt  = pick_rel;
            new_grant = 1'b1;
          end else begin
            next_gnt   = '0;
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_gnt   = '0;
        next_state = IDLE;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);

  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  tmo_q;

  // The counter reads 0 in the first cycle of a tenure, so reaching
  // HOLD_MAX-1 means the owner has already held for HOLD_MAX cycles.
  assign hold_expired = (state == BUSY) && (hold_cnt == HOLD_LAST);

  // Hold counter restarts on every grant (including a re-grant of the
  // same requester) and counts each cycle spent in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (new_grant || next_state == IDLE) begin
      hold_cnt <= '0;
    end else if (state == BUSY) begin
      hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
    end
  end

  // tmo flags only releases caused by the limit alone; an owner that
  // finishes or drops its request on the same edge left voluntarily.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= hold_expired & ~bus.done & bus.req[idx_q];
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // Output logic: everything leaving the block comes straight from registers.
  always_comb begin
    bus.gnt     = gnt_q;
    bus.gnt_idx = idx_q;
    bus.gnt_vld = (state == BUSY);
`ifdef ARB_TIMEOUT_EN
    bus.tmo     = tmo_q;
`else
    bus.tmo     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_arb_rr_4.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_4 -- self-checking bench for arb_rr_4.
//
// Directed vector table, a long-hold sequence (timeout behaviour depends on
// ARB_TIMEOUT_EN), then randomized traffic compared against a behavioural
// model that tracks the owner as an integer and searches modulo 4.
// -----------------------------------------------------------------------------
module tb_arb_rr_4;
  import arb_pkg::*;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  arb_rr_4_if bus ();

  arb_rr_4 #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state: owner = -1 means nobody holds the resource.
  int m_owner  = -1;
  int m_ptr    = 0;
  int m_last   = 0;
  int m_tenure = 0;
  bit m_tmo    = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[$];

  // First requester at or after position p, wrapping around 4 positions.
  function automatic int firstFrom(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic r, input logic [3:0] rq, input logic d);
    int  w;
    bit  vol;
    bit  forced;
    if (r) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_last   = 0;
      m_tenure = 0;
      m_tmo    = 1'b0;
      return;
    end
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      w = firstFrom(rq, m_ptr);
      if (w >= 0) begin
        m_owner  = w;
        m_last   = w;
        m_tenure = 1;
      end
    end else begin
      vol    = d || !rq[m_owner];
      forced = TMO_EN && (m_tenure >= HOLD);
      if (vol || forced) begin
        m_ptr = (m_owner + 1) % 4;
        m_tmo = forced && !vol;
        w     = firstFrom(rq, m_ptr);
        if (w >= 0) begin
          m_owner  = w;
          m_last   = w;
          m_tenure = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_tenure++;
      end
    end
  endtask

  // Drive inputs away from the clock edge, let one rising edge happen,
  // advance the model, then settle before anything is sampled.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic d);
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    @(posedge clk);
    modelStep(r, rq, d);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] ei,
                             input logic ev, input logic et);
    tests_run++;
    if (bus.gnt !== eg || bus.gnt_idx !== ei || bus.gnt_vld !== ev || bus.tmo !== et) begin
      tests_failed++;
      $display("[TB] FAIL %s: got gnt=%b idx=%0d vld=%b tmo=%b, expected gnt=%b idx=%0d vld=%b tmo=%b",
               name, bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo, eg, ei, ev, et);
    end
  endtask

  task automatic checkModel(input string name);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    checkOutput(name, eg, 2'(m_last), (m_owner >= 0), m_tmo);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rq;
    logic       r;
    logic       d;
    int         own;

    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    //              rst   req      done  gnt      idx   vld
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
    // all requesting, done every third cycle: 0,1,2,3,0 without gaps
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1});
    // owner 0 drops, only 3 left -> 3; reset mid-grant; first grant to 0
    vecs.push_back('{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1});
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
    // owner 2 alone drops -> idle with idx held, ptr=3 favours 3 over 0
    vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0});
    vecs.push_back('{1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1});
    // sole requester 1 finishing is re-granted with no drop in gnt_vld
    vecs.push_back('{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1});
    // releasing owner is last in line when others wait
    vecs.push_back('{1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1});
    vecs.push_back('{1'b0, 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 4'b0110, 1'b1, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld, 1'b0);
    end

    // Long hold by two requesters with done never asserted.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("hold_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b0);
    checkOutput("hold_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      applyStimulus(1'b0, 4'b0011, 1'b0);
`ifdef ARB_TIMEOUT_EN
      own = (c / HOLD) % 2;
      checkOutput($sformatf("hold_c%0d", c), 4'b0001 << own, 2'(own), 1'b1, (c % HOLD) == 0);
`else
      own = 0;
      checkOutput($sformatf("hold_c%0d", c), 4'b0001, 2'(own), 1'b1, 1'b0);
`endif
    end

    // Randomized traffic against the model; requests change in bursts so
    // tenures of several cycles occur.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkModel("rand_reset");
    rq = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 4) == 0);
      applyStimulus(r, rq, d);
      checkModel($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
